serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single full_adder cell (in1, in2, Cin -> out, Cout) over two WIDTH-bit operands, one bit per clock, LSB first. A start/busy/done handshake lets a requester issue one addition at a time. The final sum and carry-out are held in a result register until the next completed operation. It trades latency for area where a ripple adder of WIDTH cells is too large.

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell walks two WIDTH-bit
// operands LSB first, one bit per clock, behind a start/busy/done handshake.
// The last completed {cout, sum} is held until the next completion.

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic out,
  output logic cout
);
  assign out  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_out;
  logic             fa_cout;

  full_adder u_fa (
    .in1  (a_sh[0]),
    .in2  (b_sh[0]),
    .cin  (carry),
    .out  (fa_out),
    .cout (fa_cout)
  );

  // Shifting {fa_out, work} right and truncating gives {fa_out, work[WIDTH-1:1]}
  // for every WIDTH >= 1, including the degenerate single-bit case.
  assign work_next = WIDTH'({fa_out, work} >> 1);
  assign last      = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand capture, bit stepping and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          work  <= work_next;
          carry <= fa_cout;
          if (last) begin
            sum  <= work_next;
            cout <= fa_cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one WIDTH=8 addition from IDLE; operands are scrambled while busy.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input string name);
    int  nbusy;
    bit  seen;
    nbusy = 0;
    seen  = 0;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done8) seen = 1;
      else begin
        if (busy8) nbusy++;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        tick();
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({name, "_busy_in_done"}, 32'(busy8), 32'd0);
    check({name, "_sum"}, 32'(sum8), 32'(es));
    check({name, "_cout"}, 32'(cout8), 32'(ec));
    tick();
    check({name, "_done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  initial begin
    logic [8:0] ref9;
    logic [1:0] ref2;
    logic [7:0] ra, rb;
    logic       rc;
    int         dq[$];
    int         ndone, stable_bad, k;

    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sum: 8'h8D, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};

    rst_n = 1'b0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    repeat (2) tick();
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_sum",  32'(sum8), 0);
    check("rst_cout", 32'(cout8), 0);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 4; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // Randomized against arithmetic model
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run8(ra, rb, rc, ref9[7:0], ref9[8], $sformatf("rnd%0d", i));
    end

    // Start pulsed during RUN is ignored
    a8 = 8'h5A; b8 = 8'h33; cin8 = 0; start8 = 1;
    tick();
    start8 = 0;
    tick(); tick();
    start8 = 1; a8 = 8'h00; b8 = 8'h00;
    tick();
    start8 = 0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) ndone++;
      tick();
    end
    check("ign_done_count", 32'(ndone), 1);
    check("ign_sum", 32'(sum8), 32'h8D);
    check("ign_busy_after", 32'(busy8), 0);

    // start held high: one result every WIDTH+2 cycles
    a8 = 8'h12; b8 = 8'h34; cin8 = 1; start8 = 1;
    stable_bad = 0;
    for (int c = 0; c < 52; c++) begin
      tick();
      if (done8) dq.push_back(c);
      if (dq.size() > 0 && {cout8, sum8} !== 9'h047) stable_bad++;
    end
    start8 = 0;
    check("hold_pulses", 32'(dq.size() >= 4), 1);
    for (int i = 1; i < dq.size(); i++)
      check($sformatf("hold_period%0d", i), 32'(dq[i] - dq[i-1]), 10);
    check("hold_sum_stable", 32'(stable_bad), 0);
    k = 0;
    while (k < 30 && (busy8 || done8)) begin
      tick();
      k++;
    end
    check("hold_drain_timeout", 32'(k < 30), 1);

    // Asynchronous reset mid-operation
    a8 = 8'h77; b8 = 8'h11; cin8 = 0; start8 = 1;
    tick();
    start8 = 0;
    tick(); tick(); tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy8), 0);
    check("arst_done", 32'(done8), 0);
    check("arst_sum",  32'(sum8), 0);
    check("arst_cout", 32'(cout8), 0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #3;
      if (done8 || busy8) ndone++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    check("arst_no_done", 32'(ndone), 0);
    run8(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, "post_rst");

    // WIDTH=1: all operand combinations
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2);
      ref2 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
      start1 = 1;
      tick();
      start1 = 0;
      check($sformatf("w1_%0d_busy", i), 32'({busy1, done1}), 32'b10);
      tick();
      check($sformatf("w1_%0d_done", i), 32'({busy1, done1}), 32'b01);
      check($sformatf("w1_%0d_res", i), 32'({cout1, sum1}), 32'(ref2));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
